// File: rtl/z_link_tx.sv
// z_link_tx: FPGA1-side result transmitter.
// Triggers the linear layer on a start edge, captures its OUT_DIM-element
// result vector and streams it to FPGA2 over a LINK_W-bit GPIO bus using a
// 4-phase valid/ack handshake, least-significant beat of element 0 first.
module z_link_tx #(
  parameter int OUT_DIM     = 4,
  parameter int Z_W         = 4,
  parameter int LINK_W      = 4,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   lin_start,
  input  logic                   lin_done,
  input  logic [OUT_DIM*Z_W-1:0] z_vec,
  output logic [LINK_W-1:0]      link_data,
  output logic                   link_valid,
  output logic                   link_last,
  input  logic                   link_ack,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int BEATS = (Z_W + LINK_W - 1) / LINK_W;
  localparam int EXT_W = BEATS * LINK_W;
  localparam int NB    = OUT_DIM * BEATS;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NB - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);
  localparam bit               TO_EN    = (ACK_TIMEOUT > 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COMPUTE,
    S_SETUP,
    S_REQ,
    S_REL,
    S_DONE,
    S_ERR
  } state_t;

  state_t            state;
  logic              start_q;
  logic              ack_m;
  logic              ack_s;
  logic [IDX_W-1:0]  beat_idx;
  logic [IDX_W-1:0]  nxt_idx;
  logic [CNT_W-1:0]  phase_cnt;
  logic [LINK_W-1:0] hold [NB];
  logic [LINK_W-1:0] cap  [NB];
  logic [EXT_W-1:0]  elem_ext;
  logic              start_edge;
  logic              is_last;
  logic              timed_out;

  // Split the incoming vector into link-wide beats, each element zero-extended
  // to a whole number of beats; the flat beat index walks element by element.
  always_comb begin
    elem_ext = '0;
    cap      = '{default: '0};
    for (int unsigned e = 0; e < OUT_DIM; e++) begin
      elem_ext            = '0;
      elem_ext[Z_W-1:0]   = z_vec[e*Z_W +: Z_W];
      for (int unsigned b = 0; b < BEATS; b++) begin
        cap[e*BEATS + b] = elem_ext[b*LINK_W +: LINK_W];
      end
    end
  end

  // Edge detect, last-beat flag, next beat index and phase timeout.
  always_comb begin
    start_edge = start & ~start_q;
    is_last    = (beat_idx == IDX_LAST);
    nxt_idx    = is_last ? beat_idx : beat_idx + 1'b1;
    timed_out  = TO_EN && (phase_cnt == CNT_LAST);
  end

  // Transfer state machine with registered outputs and ack synchroniser.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      start_q    <= 1'b0;
      ack_m      <= 1'b0;
      ack_s      <= 1'b0;
      beat_idx   <= '0;
      phase_cnt  <= '0;
      hold       <= '{default: '0};
      lin_start  <= 1'b0;
      link_data  <= '0;
      link_valid <= 1'b0;
      link_last  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      start_q   <= start;
      ack_m     <= link_ack;
      ack_s     <= ack_m;
      lin_start <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start_edge) begin
            state     <= S_COMPUTE;
            lin_start <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
            beat_idx  <= '0;
          end
        end
        S_COMPUTE: begin
          // lin_start is still high in the first COMPUTE cycle, masking a
          // stale done from the previous run.
          if (!lin_start && lin_done) begin
            hold      <= cap;
            link_data <= cap[0];
            link_last <= (NB == 1);
            state     <= S_SETUP;
          end
        end
        S_SETUP: begin
          link_valid <= 1'b1;
          phase_cnt  <= '0;
          state      <= S_REQ;
        end
        S_REQ: begin
          if (ack_s) begin
            link_valid <= 1'b0;
            phase_cnt  <= '0;
            state      <= S_REL;
          end else if (timed_out) begin
            link_valid <= 1'b0;
            link_last  <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b1;
            state      <= S_ERR;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end
        S_REL: begin
          if (!ack_s) begin
            if (is_last) begin
              done      <= 1'b1;
              busy      <= 1'b0;
              link_last <= 1'b0;
              state     <= S_DONE;
            end else begin
              beat_idx  <= nxt_idx;
              link_data <= hold[nxt_idx];
              link_last <= (nxt_idx == IDX_LAST);
              state     <= S_SETUP;
            end
          end else if (timed_out) begin
            link_last <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b1;
            state     <= S_ERR;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_z_link_tx.sv
// tb_z_link_tx: self-checking bench for z_link_tx (3 elements, 6-bit results
// over a 4-bit link, so every element needs two beats with zero padding).
module tb_z_link_tx;

  localparam int OUT_DIM = 3;
  localparam int Z_W     = 6;
  localparam int LINK_W  = 4;
  localparam int ACK_TO  = 16;
  localparam int BEATS   = (Z_W + LINK_W - 1) / LINK_W;
  localparam int NB      = OUT_DIM * BEATS;
  localparam int ZV_W    = OUT_DIM * Z_W;
  localparam int BV_W    = NB * LINK_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              lin_start;
  logic              lin_done;
  logic [ZV_W-1:0]   z_vec;
  logic [LINK_W-1:0] link_data;
  logic              link_valid;
  logic              link_last;
  logic              link_ack;
  logic              busy;
  logic              done;
  logic              err;

  z_link_tx #(
    .OUT_DIM     (OUT_DIM),
    .Z_W         (Z_W),
    .LINK_W      (LINK_W),
    .ACK_TIMEOUT (ACK_TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .lin_start  (lin_start),
    .lin_done   (lin_done),
    .z_vec      (z_vec),
    .link_data  (link_data),
    .link_valid (link_valid),
    .link_last  (link_last),
    .link_ack   (link_ack),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int checks    = 0;
  int failures  = 0;
  int cyc       = 0;
  int ls_count  = 0;

  // Free-running cycle counter and count of lin_start pulse cycles.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (lin_start === 1'b1) ls_count <= ls_count + 1;
  end

  typedef struct {
    logic [ZV_W-1:0] z;
    logic [BV_W-1:0] exp;
    int              dly;
    int              mode;
    bit              extra;
  } vec_t;

  vec_t tbl [4];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: element e is an unsigned Z_W-bit number; beat b of it is the
  // b-th LINK_W-bit digit, elements in order, low digit first.
  function automatic logic [BV_W-1:0] model_beats(input logic [ZV_W-1:0] z);
    logic [BV_W-1:0] r;
    int unsigned     v;
    r = '0;
    for (int e = 0; e < OUT_DIM; e++) begin
      v = 32'(z[e*Z_W +: Z_W]);
      for (int b = 0; b < BEATS; b++) begin
        r[(e*BEATS + b)*LINK_W +: LINK_W] = LINK_W'((v >> (b*LINK_W)) % (1 << LINK_W));
      end
    end
    return r;
  endfunction

  // Press start and play the linear layer. mode 0: done pulse after lat
  // cycles; 1: done held high as a level; 2: done already high in the
  // lin_start cycle with decoy data.
  task automatic start_capture(input logic [ZV_W-1:0] z, input int mode, input int lat);
    if (mode == 1) begin
      z_vec    = z;
      lin_done = 1'b1;
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    check("lin_start_pulse", lin_start, 1);
    check("busy_after_start", busy, 1);
    check("flags_cleared", {done, err}, 0);
    case (mode)
      0: begin
        tick();
        check("lin_start_single", lin_start, 0);
        repeat (lat) tick();
        z_vec    = z;
        lin_done = 1'b1;
        tick();
        lin_done = 1'b0;
        z_vec    = ZV_W'($urandom);
      end
      1: begin
        tick();
        check("lin_start_single", lin_start, 0);
      end
      default: begin
        lin_done = 1'b1;
        z_vec    = ~z;
        tick();
        check("lin_start_single", lin_start, 0);
        z_vec = z;
        tick();
        lin_done = 1'b0;
        z_vec    = ZV_W'($urandom);
      end
    endcase
  endtask

  // FPGA2 peer for one beat. Returns the cycle at which valid was seen.
  // With abort set, returns as soon as valid has dropped (in REL).
  task automatic peer_beat(input int k, input logic [LINK_W-1:0] exp_d, input int dly,
                           input bit extra, input bit abort, output int t_valid);
    logic [LINK_W-1:0] prev_d;
    logic [LINK_W-1:0] d0;
    int                n;
    bit                stable;
    n      = 0;
    prev_d = link_data;
    while (link_valid !== 1'b1 && n < 300) begin
      prev_d = link_data;
      tick();
      n++;
    end
    t_valid = cyc;
    check($sformatf("beat%0d_valid_rise", k), link_valid, 1);
    check($sformatf("beat%0d_setup_stable", k), link_data, prev_d);
    check($sformatf("beat%0d_data", k), link_data, exp_d);
    check($sformatf("beat%0d_last", k), link_last, (k == NB - 1));
    d0     = link_data;
    stable = 1'b1;
    for (int i = 0; i < dly; i++) begin
      if (extra && i == dly / 2) start = 1'b1;
      tick();
      start = 1'b0;
      if (link_data !== d0 || link_valid !== 1'b1) stable = 1'b0;
    end
    link_ack = 1'b1;
    n = 0;
    while (link_valid === 1'b1 && n < 300) begin
      tick();
      n++;
      if (link_data !== d0) stable = 1'b0;
    end
    check($sformatf("beat%0d_ack_latency", k), n, 3);
    if (!abort) begin
      for (int i = 0; i < dly; i++) begin
        tick();
        if (link_data !== d0 || link_valid !== 1'b0) stable = 1'b0;
      end
      link_ack = 1'b0;
      repeat (2) begin
        tick();
        if (link_data !== d0 || link_valid !== 1'b0) stable = 1'b0;
      end
    end
    check($sformatf("beat%0d_data_stable", k), stable, 1);
  endtask

  task automatic do_transfer(input logic [ZV_W-1:0] z, input logic [BV_W-1:0] exp,
                             input int dly, input int mode, input int lat, input bit extra);
    int base;
    int tv;
    int tprev;
    int n;
    base  = ls_count;
    tprev = 0;
    start_capture(z, mode, lat);
    for (int k = 0; k < NB; k++) begin
      peer_beat(k, exp[k*LINK_W +: LINK_W], dly, extra && (k == 1), 1'b0, tv);
      if (mode == 1 && k == 0) z_vec = ZV_W'($urandom);
      if (dly == 0 && k > 0) check("beat_period", tv - tprev, 7);
      tprev = tv;
    end
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("done_set", done, 1);
    check("done_outputs", {busy, err, link_valid, link_last}, 0);
    check("done_data_hold", link_data, exp[(NB-1)*LINK_W +: LINK_W]);
    lin_done = 1'b0;
    tick();
    check("lin_start_count", ls_count - base, 1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [ZV_W-1:0] z;
    int              n;
    int              c;
    int              tv;

    tbl[0] = '{18'h3A56F, 24'h3A152F, 0,  0, 1'b0};
    tbl[1] = '{18'h20FC0, 24'h203F00, 10, 0, 1'b1};
    tbl[2] = '{18'h07A91, 24'h072A11, 2,  1, 1'b0};
    tbl[3] = '{18'h300FE, 24'h30033E, 1,  2, 1'b0};

    // Reset with a coincident start press: reset wins.
    rst      = 1'b1;
    start    = 1'b1;
    lin_done = 1'b0;
    link_ack = 1'b0;
    z_vec    = '0;
    repeat (2) tick();
    check("reset_outputs", {link_data, link_valid, link_last, lin_start, busy, done, err}, 0);
    rst   = 1'b0;
    start = 1'b0;
    repeat (2) tick();
    check("start_with_rst_ignored", {busy, lin_start}, 0);

    // Directed vectors.
    for (int i = 0; i < 4; i++) begin
      do_transfer(tbl[i].z, tbl[i].exp, tbl[i].dly, tbl[i].mode, 0, tbl[i].extra);
    end

    // Timeout in REQ: peer never acknowledges.
    start_capture(ZV_W'($urandom), 0, 0);
    n = 0;
    while (link_valid !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check("req_valid_seen", link_valid, 1);
    c = 1;
    while (err !== 1'b1 && c < 60) begin
      tick();
      c++;
    end
    check("req_timeout_cycles", c, 17);
    check("err_outputs", {err, link_valid, busy, done, link_last}, 5'b10000);
    tick();
    check("err_level_held", err, 1);

    // Timeout in REL: ack stuck high.
    start_capture(ZV_W'($urandom), 0, 1);
    n = 0;
    while (link_valid !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    link_ack = 1'b1;
    n = 0;
    while (link_valid === 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check("rel_valid_low", link_valid, 0);
    c = 1;
    while (err !== 1'b1 && c < 60) begin
      tick();
      c++;
    end
    check("rel_timeout_cycles", c, 17);
    check("rel_err_outputs", {err, link_valid, busy, done}, 4'b1000);
    link_ack = 1'b0;
    repeat (3) tick();

    // Recovery from ERR with a full transfer.
    z = ZV_W'($urandom);
    do_transfer(z, model_beats(z), 1, 0, 0, 1'b0);

    // Reset during REL of element 2, then a fresh transfer from beat 0.
    z = ZV_W'($urandom);
    start_capture(z, 0, 1);
    for (int k = 0; k < 4; k++) peer_beat(k, model_beats(z) >> (k*LINK_W), 1, 1'b0, 1'b0, tv);
    peer_beat(4, model_beats(z) >> (4*LINK_W), 1, 1'b0, 1'b1, tv);
    check("in_rel_before_rst", {busy, link_valid}, 2'b10);
    rst      = 1'b1;
    link_ack = 1'b0;
    tick();
    check("rst_mid_outputs", {link_data, link_valid, link_last, lin_start, busy, done, err}, 0);
    rst = 1'b0;
    repeat (2) tick();
    check("idle_after_rst", {busy, done, err}, 0);
    z = ZV_W'($urandom);
    do_transfer(z, model_beats(z), 0, 0, 2, 1'b0);

    // Randomized transfers against the reference model.
    for (int r = 0; r < 8; r++) begin
      z = ZV_W'($urandom);
      do_transfer(z, model_beats(z), $urandom_range(0, 4), $urandom_range(0, 2),
                  $urandom_range(0, 3), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
